// File: rtl/mult_share_arbiter_if.sv
// Request/response bundle between the requesters and the shared-multiplier arbiter.
// The master side drives requests and consumes results; the slave side is the arbiter.
interface mult_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [2*W-1:0]    resp_product;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_product
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_product
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one registered W x W multiplier (1-cycle latency)
// between NREQ requesters, returning each product tagged with the owner's index.
module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                     io_clk,
  input  logic                     io_rst,
  mult_share_arbiter_if.slave      bus,
  output logic [W-1:0]             mul_a,
  output logic [W-1:0]             mul_b,
  input  logic [2*W-1:0]           mul_p,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  id;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  cand_idx;
  logic            grant_found;
  int              cand;

  // Scan starting just after the last winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    winner      = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(rr_ptr) + k) % NREQ;
      cand_idx = IDW'(cand);
      if (!grant_found && bus.req_valid[cand_idx]) begin
        grant_found = 1'b1;
        winner      = cand_idx;
      end
    end
  end

  assign bus.req_ready = (state == IDLE && grant_found) ? (NREQ'(1) << winner) : '0;
  assign busy          = (state != IDLE);
  assign mul_a         = op_a;
  assign mul_b         = op_b;

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      state            <= IDLE;
      rr_ptr           <= IDW'(NREQ - 1);
      id               <= '0;
      op_a             <= '0;
      op_b             <= '0;
      bus.resp_valid   <= 1'b0;
      bus.resp_id      <= '0;
      bus.resp_product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a   <= bus.req_a[winner*W +: W];
            op_b   <= bus.req_b[winner*W +: W];
            id     <= winner;
            rr_ptr <= winner;
            state  <= ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        // The multiplier registered the operands at the end of ISSUE, so its product is valid here.
        CAPTURE: begin
          bus.resp_product <= mul_p;
          bus.resp_id      <= id;
          bus.resp_valid   <= 1'b1;
          state            <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural 1-cycle registered multiplier.
module tb_mult_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic             io_clk;
  logic             io_rst;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [2*W-1:0]   mul_p;
  logic             busy;
  int               errors;
  int               checks;
  logic [NREQ-1:0]  g;

  mult_share_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bif ();

  mult_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .io_clk (io_clk),
    .io_rst (io_rst),
    .bus    (bif.slave),
    .mul_a  (mul_a),
    .mul_b  (mul_b),
    .mul_p  (mul_p),
    .busy   (busy)
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  // Stand-in for the external multiplier: product registered one cycle after the operands.
  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) mul_p <= '0;
    else        mul_p <= mul_a * mul_b;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  task automatic waitGrant(output logic [NREQ-1:0] gnt);
    gnt = '0;
    for (int n = 0; n < 12 && gnt == '0; n++) begin
      if (bif.req_ready != '0) gnt = bif.req_ready;
      else tick();
    end
    if (gnt == '0) checkOutput("grant_timeout", 32'd0, 32'd1);
  endtask

  // One isolated transaction with resp_ready held high, checking exact 3-cycle latency.
  task automatic applyStimulus(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2*W-1:0] exp_p);
    logic [NREQ-1:0] gnt;
    bif.req_a[idx*W +: W] = a;
    bif.req_b[idx*W +: W] = b;
    bif.req_valid[idx]    = 1'b1;
    #1;
    waitGrant(gnt);
    checkOutput("grant", 32'(gnt), 32'(1 << idx));
    tick();
    bif.req_valid[idx] = 1'b0;
    checkOutput("lat_t1_valid", 32'(bif.resp_valid), 32'd0);
    tick();
    checkOutput("lat_t2_valid", 32'(bif.resp_valid), 32'd0);
    tick();
    checkOutput("resp_valid", 32'(bif.resp_valid), 32'd1);
    checkOutput("resp_id", 32'(bif.resp_id), 32'(idx));
    checkOutput("resp_product", 32'(bif.resp_product), 32'(exp_p));
    tick();
    checkOutput("resp_done", 32'(bif.resp_valid), 32'd0);
  endtask

  task automatic doReset();
    io_rst        = 1'b1;
    bif.req_valid = '0;
    tick();
    io_rst = 1'b0;
    tick();
  endtask

  always @(negedge io_clk)
    if (!io_rst) checkOutput("ready_onehot0", 32'($onehot0(bif.req_ready)), 32'd1);

  initial begin
    logic [2*W-1:0] prod_tab [NREQ];
    prod_tab[0] = 8'd15; prod_tab[1] = 8'd30; prod_tab[2] = 8'd45; prod_tab[3] = 8'd60;
    errors = 0;
    checks = 0;
    io_rst = 1'b1;
    bif.req_valid  = '0;
    bif.req_a      = '0;
    bif.req_b      = '0;
    bif.resp_ready = 1'b1;
    tick();
    tick();
    checkOutput("rst_req_ready", 32'(bif.req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(bif.resp_valid), 32'd0);
    checkOutput("rst_resp_id", 32'(bif.resp_id), 32'd0);
    checkOutput("rst_resp_product", 32'(bif.resp_product), 32'd0);
    checkOutput("rst_mul_a", 32'(mul_a), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    io_rst = 1'b0;
    tick();

    $display("[TB] reset during ISSUE");
    bif.req_a[3:0] = 4'd3;
    bif.req_b[3:0] = 4'd5;
    bif.req_valid  = 4'b0001;
    #1;
    checkOutput("t1_grant", 32'(bif.req_ready), 32'b0001);
    tick();
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_mul_a", 32'(mul_a), 32'd3);
    checkOutput("t1_mul_b", 32'(mul_b), 32'd5);
    io_rst        = 1'b1;
    bif.req_valid = '0;
    #1;
    checkOutput("t1_abort_busy", 32'(busy), 32'd0);
    checkOutput("t1_abort_mul_a", 32'(mul_a), 32'd0);
    checkOutput("t1_abort_mul_b", 32'(mul_b), 32'd0);
    tick();
    io_rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      checkOutput("t1_no_resp", 32'(bif.resp_valid), 32'd0);
      checkOutput("t1_idle", 32'(busy), 32'd0);
    end

    $display("[TB] single request from req1");
    applyStimulus(1, 4'd3, 4'd5, 8'd15);

    $display("[TB] all requesters active");
    doReset();
    for (int i = 0; i < NREQ; i++) begin
      bif.req_a[i*W +: W] = W'(i + 1);
      bif.req_b[i*W +: W] = 4'd15;
    end
    bif.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      waitGrant(g);
      checkOutput("t3_grant", 32'(g), 32'(1 << (k % NREQ)));
      tick();
      if (k == 4) bif.req_valid = '0;
      checkOutput("t3_ready_busy", 32'(bif.req_ready), 32'd0);
      tick();
      tick();
      checkOutput("t3_resp_valid", 32'(bif.resp_valid), 32'd1);
      checkOutput("t3_resp_id", 32'(bif.resp_id), 32'(k % NREQ));
      checkOutput("t3_resp_product", 32'(bif.resp_product), 32'(prod_tab[k % NREQ]));
      tick();
    end

    $display("[TB] corner operands");
    applyStimulus(0, 4'd15, 4'd15, 8'd225);
    applyStimulus(2, 4'd0, 4'd9, 8'd0);
    applyStimulus(3, 4'd15, 4'd1, 8'd15);
    checkOutput("mul_a_hold", 32'(mul_a), 32'd15);
    checkOutput("mul_b_hold", 32'(mul_b), 32'd1);

    $display("[TB] response backpressure");
    bif.resp_ready = 1'b0;
    bif.req_a[3:0] = 4'd7;
    bif.req_b[3:0] = 4'd9;
    bif.req_valid  = 4'b0001;
    #1;
    waitGrant(g);
    checkOutput("t5_grant", 32'(g), 32'b0001);
    tick();
    bif.req_a[7:4] = 4'd4;
    bif.req_b[7:4] = 4'd4;
    bif.req_valid  = 4'b0010;
    tick();
    tick();
    for (int n = 0; n < 5; n++) begin
      checkOutput("t5_hold_valid", 32'(bif.resp_valid), 32'd1);
      checkOutput("t5_hold_id", 32'(bif.resp_id), 32'd0);
      checkOutput("t5_hold_product", 32'(bif.resp_product), 32'd63);
      checkOutput("t5_hold_ready", 32'(bif.req_ready), 32'd0);
      tick();
    end
    bif.resp_ready = 1'b1;
    #1;
    tick();
    checkOutput("t5_released", 32'(bif.resp_valid), 32'd0);
    checkOutput("t5_next_grant", 32'(bif.req_ready), 32'b0010);

    $display("[TB] withdrawn request is skipped");
    tick();
    bif.req_a[11:8]  = 4'd5;
    bif.req_b[11:8]  = 4'd5;
    bif.req_a[15:12] = 4'd6;
    bif.req_b[15:12] = 4'd7;
    bif.req_valid    = 4'b1100;
    tick();
    bif.req_valid = 4'b1000;
    tick();
    checkOutput("t6_req1_id", 32'(bif.resp_id), 32'd1);
    checkOutput("t6_req1_product", 32'(bif.resp_product), 32'd16);
    tick();
    checkOutput("t6_grant_req3", 32'(bif.req_ready), 32'b1000);
    tick();
    bif.req_valid = '0;
    tick();
    tick();
    checkOutput("t6_resp_valid", 32'(bif.resp_valid), 32'd1);
    checkOutput("t6_resp_id", 32'(bif.resp_id), 32'd3);
    checkOutput("t6_resp_product", 32'(bif.resp_product), 32'd42);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
